// File: rtl/statetype_package.sv
`default_nettype none
// ============================================================================
// Module      : statetype_package
// Description : Shared state encodings and constants for the keypad slice:
//               row-scanner states, key-event controller states, debounce
//               default and one-hot helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package statetype_package;

    // Debounce window in clk cycles used when the controller is not overridden
    localparam int DB_CYCLES_DEFAULT = 20000;

    // Row scanner states
    typedef enum logic [1:0] {
        SCAN_IDLE   = 2'd0,
        SCAN_DRIVE  = 2'd1,
        SCAN_SETTLE = 2'd2,
        SCAN_SAMPLE = 2'd3
    } scan_state_t;

    // Key-event controller states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        CAPTURE    = 3'd2,
        HELD       = 3'd3,
        RELEASE_DB = 3'd4
    } kec_state_t;

    // True when exactly one of the four bits is set
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Index of the set bit of a one-hot nibble (highest set bit wins)
    function automatic logic [1:0] onehot4_to_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage : statetype_package
`default_nettype wire

// File: rtl/keypad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_decoder
// Description : Combinational translation of a one-hot row/column pair into
//               the hex code printed on the 4x4 keypad.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_decoder
    import statetype_package::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] code
);

    logic [1:0] w_row_idx;
    logic [1:0] w_col_idx;

    assign w_row_idx = onehot4_to_idx(row);
    assign w_col_idx = onehot4_to_idx(col);

    // Keypad legend lookup indexed by {row, column}
    always_comb begin
        code = 4'h0;
        case ({w_row_idx, w_col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
    end

endmodule : keypad_decoder
`default_nettype wire

// File: rtl/key_event_controller.sv
`default_nettype none
// ============================================================================
// Module      : key_event_controller
// Description : Synchronizes keypad columns, debounces a single key press and
//               release, and publishes the last two accepted hex codes with a
//               one-cycle acceptance pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_controller
    import statetype_package::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols_raw,
    input  logic [3:0] rows,
    input  logic       change,
    output logic [3:0] cols_sync,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_valid,
    output logic       busy
);

    localparam int                 c_CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

    logic [3:0]         r_sync1;
    kec_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_row_l;
    logic [3:0]         r_col_l;

    logic               w_sel;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [3:0]         w_code;

    // Level of the synchronized column belonging to the latched key
    assign w_sel = |(cols_sync & r_col_l);

    // Debounce counter advance; holds at all-ones instead of wrapping
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    keypad_decoder u_decoder (
        .row  (r_row_l),
        .col  (r_col_l),
        .code (w_code)
    );

    // Two-flop synchronizer on the asynchronous keypad columns
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 4'b0000;
            cols_sync <= 4'b0000;
        end else begin
            r_sync1   <= cols_raw;
            cols_sync <= r_sync1;
        end
    end

    // Press/release debounce FSM; busy and key_valid are set together with
    // the state they describe so both stay registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_row_l   <= 4'b0000;
            r_col_l   <= 4'b0000;
            digit_new <= 4'h0;
            digit_old <= 4'h0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (change) begin
                        r_row_l <= rows;
                        r_col_l <= cols_sync;
                        r_cnt   <= '0;
                        // Several keys at once are ambiguous: stay idle
                        if (is_onehot4(rows) && is_onehot4(cols_sync)) begin
                            r_state <= PRESS_DB;
                            busy    <= 1'b1;
                        end
                    end
                end
                PRESS_DB: begin
                    if (w_sel) begin
                        if (r_cnt == c_DB_LAST) begin
                            r_state   <= CAPTURE;
                            r_cnt     <= '0;
                            key_valid <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    digit_old <= digit_new;
                    digit_new <= w_code;
                    r_state   <= HELD;
                    r_cnt     <= '0;
                end
                HELD: begin
                    // A held key waits here for release and never re-fires
                    if (!w_sel) begin
                        r_state <= RELEASE_DB;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_DB: begin
                    if (!w_sel) begin
                        if (r_cnt == c_DB_LAST) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            busy    <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : key_event_controller
`default_nettype wire

// File: tb/tb_key_event_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_controller
// Description : Directed self-checking bench for key_event_controller with a
//               four-cycle debounce window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_controller;

    localparam int c_DB = 4;

    logic       clk;
    logic       reset;
    logic [3:0] cols_raw;
    logic [3:0] rows;
    logic       change;
    logic [3:0] cols_sync;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_valid;
    logic       busy;

    int checks;
    int errors;
    int kv_count;
    int kv_base;

    key_event_controller #(
        .DB_CYCLES (c_DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols_raw  (cols_raw),
        .rows      (rows),
        .change    (change),
        .cols_sync (cols_sync),
        .digit_new (digit_new),
        .digit_old (digit_old),
        .key_valid (key_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count acceptance pulses; each one is high for exactly one cycle
    always @(posedge clk) begin
        if (key_valid === 1'b1) begin
            kv_count <= kv_count + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a key, let it reach cols_sync, then strobe change for one cycle
    task automatic press(input logic [3:0] r, input logic [3:0] c);
        rows     = r;
        cols_raw = c;
        tick(2);
        change = 1'b1;
        tick(1);
        change = 1'b0;
    endtask

    task automatic release_key();
        cols_raw = 4'b0000;
        tick(10);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        kv_count = 0;
        reset    = 1'b1;
        cols_raw = 4'b0000;
        rows     = 4'b0000;
        change   = 1'b0;
        tick(2);

        // Reset state
        chk("rst_digit_new", 32'(digit_new), 32'h0);
        chk("rst_digit_old", 32'(digit_old), 32'h0);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_cols_sync", 32'(cols_sync), 32'h0);
        reset = 1'b0;
        tick(2);

        // Key 6 (row1/col2), with synchronizer latency observed on the way
        kv_base  = kv_count;
        rows     = 4'b0010;
        cols_raw = 4'b0100;
        tick(1);
        chk("sync_lat1", 32'(cols_sync), 32'h0);
        tick(1);
        chk("sync_lat2", 32'(cols_sync), 32'h4);
        change = 1'b1;
        tick(1);
        change = 1'b0;
        chk("k6_busy_pressdb", 32'(busy), 32'h1);
        tick(10);
        chk("k6_pulses",    32'(kv_count - kv_base), 32'd1);
        chk("k6_digit_new", 32'(digit_new), 32'h6);
        chk("k6_digit_old", 32'(digit_old), 32'h0);
        chk("k6_busy_held", 32'(busy), 32'h1);
        release_key();
        chk("k6_busy_released", 32'(busy), 32'h0);

        // Key 0 (row3/col1) with exact acceptance timing
        kv_base = kv_count;
        press(4'b1000, 4'b0010);
        tick(3);
        chk("k0_kv_early", 32'(key_valid), 32'h0);
        tick(1);
        chk("k0_kv_pulse", 32'(key_valid), 32'h1);
        tick(1);
        chk("k0_kv_drop", 32'(key_valid), 32'h0);
        tick(5);
        chk("k0_pulses",    32'(kv_count - kv_base), 32'd1);
        chk("k0_digit_new", 32'(digit_new), 32'h0);
        chk("k0_digit_old", 32'(digit_old), 32'h6);
        release_key();

        // Key A (row0/col3)
        kv_base = kv_count;
        press(4'b0001, 4'b1000);
        tick(10);
        chk("kA_pulses",    32'(kv_count - kv_base), 32'd1);
        chk("kA_digit_new", 32'(digit_new), 32'hA);
        chk("kA_digit_old", 32'(digit_old), 32'h0);
        release_key();

        // Bounce: column drops before the debounce window completes
        kv_base = kv_count;
        press(4'b0001, 4'b0001);
        cols_raw = 4'b0000;
        tick(1);
        cols_raw = 4'b0001;
        tick(1);
        cols_raw = 4'b0000;
        tick(6);
        chk("bounce_pulses",    32'(kv_count - kv_base), 32'd0);
        chk("bounce_busy",      32'(busy), 32'h0);
        chk("bounce_digit_new", 32'(digit_new), 32'hA);
        chk("bounce_digit_old", 32'(digit_old), 32'h0);

        // Long hold of key 7 with a short release glitch
        kv_base = kv_count;
        press(4'b0100, 4'b0001);
        tick(100);
        cols_raw = 4'b0000;
        tick(2);
        cols_raw = 4'b0001;
        tick(5);
        chk("glitch_busy",      32'(busy), 32'h1);
        chk("glitch_pulses",    32'(kv_count - kv_base), 32'd1);
        chk("glitch_digit_new", 32'(digit_new), 32'h7);
        chk("glitch_digit_old", 32'(digit_old), 32'hA);
        tick(20);
        chk("glitch_no_retrig", 32'(kv_count - kv_base), 32'd1);
        release_key();
        chk("glitch_busy_released", 32'(busy), 32'h0);

        // Two columns at once are rejected
        kv_base = kv_count;
        press(4'b0010, 4'b0110);
        chk("multi_busy_now", 32'(busy), 32'h0);
        tick(8);
        chk("multi_busy",      32'(busy), 32'h0);
        chk("multi_pulses",    32'(kv_count - kv_base), 32'd0);
        chk("multi_digit_new", 32'(digit_new), 32'h7);
        release_key();

        // Reset during press debounce discards the key
        press(4'b0001, 4'b0001);
        chk("rstmid_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("rstmid_digit_new", 32'(digit_new), 32'h0);
        chk("rstmid_digit_old", 32'(digit_old), 32'h0);
        chk("rstmid_busy",      32'(busy),      32'h0);
        chk("rstmid_key_valid", 32'(key_valid), 32'h0);
        chk("rstmid_cols_sync", 32'(cols_sync), 32'h0);
        tick(2);
        reset   = 1'b0;
        kv_base = kv_count;
        tick(12);
        chk("rstmid_no_pulse", 32'(kv_count - kv_base), 32'd0);
        chk("rstmid_idle",     32'(busy), 32'h0);

        // A fresh change after reset is accepted again
        kv_base = kv_count;
        change  = 1'b1;
        tick(1);
        change = 1'b0;
        tick(10);
        chk("fresh_pulses",    32'(kv_count - kv_base), 32'd1);
        chk("fresh_digit_new", 32'(digit_new), 32'h1);
        chk("fresh_digit_old", 32'(digit_old), 32'h0);
        release_key();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_key_event_controller
`default_nettype wire
